// File: rtl/asym_fifo_write_wider_pkg.sv
// Shared helpers for the wide-write / narrow-read FIFO: width derivation and
// parameter legality checks used at elaboration.
package asym_fifo_pkg;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned ratio_of(input int unsigned dwa, input int unsigned dwb);
    return (dwb == 0) ? 0 : dwa / dwb;
  endfunction

  function automatic int unsigned log2_ratio(input int unsigned dwa, input int unsigned dwb);
    return $clog2(max_u(1, ratio_of(dwa, dwb)));
  endfunction

  // Wide word must split into a power-of-two number (>= 2) of whole narrow lanes.
  function automatic bit params_ok(input int unsigned dwa, input int unsigned dwb);
    int unsigned r;
    if (dwb == 0) return 1'b0;
    r = dwa / dwb;
    return (dwa % dwb == 0) && (r >= 2) && ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/asym_fifo_write_wider_if.sv
// Producer (wide) and consumer (narrow) handshake bundle for asym_fifo_write_wider.
// slave = the FIFO side, master = the surrounding logic.
interface asym_fifo_write_wider_if
  import asym_fifo_pkg::*;
#(
  parameter int unsigned AWA = 4,
  parameter int unsigned DWA = 16,
  parameter int unsigned DWB = 4
) ();

  localparam int unsigned LW = AWA + log2_ratio(DWA, DWB) + 1;

  logic           s_valid;
  logic           s_ready;
  logic [DWA-1:0] s_data;
  logic           m_valid;
  logic           m_ready;
  logic [DWB-1:0] m_data;
  logic [LW-1:0]  level;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, level
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, level
  );

endinterface

// File: rtl/asym_fifo_write_wider_mem.sv
// Narrow-word simple dual-port RAM: one write stores RATIO lanes at consecutive
// narrow addresses; registered narrow read. Array contents are not reset.
module asym_fifo_mem #(
  parameter int unsigned AWA   = 4,
  parameter int unsigned DWB   = 4,
  parameter int unsigned RATIO = 4,
  parameter int unsigned LR    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_wr_en,
  input  logic [AWA-1:0]            i_wr_addr,
  input  logic [RATIO-1:0][DWB-1:0] i_wr_data,
  input  logic                      i_rd_en,
  input  logic [AWA+LR-1:0]         i_rd_addr,
  output logic [DWB-1:0]            o_rd_data
);

  localparam int unsigned DEPTH = (1 << AWA) * RATIO;

  logic [DWB-1:0] r_mem [DEPTH];
  logic [DWB-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int unsigned j = 0; j < RATIO; j++) begin
        r_mem[{i_wr_addr, LR'(j)}] <= i_wr_data[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/asym_fifo_write_wider.sv
// Single-clock FIFO: wide words in, narrow lanes out, registered output stage.
// ASYM_FIFO_MSB_LANE_FIRST_EN defined: s_data MSB lane is emitted first.
module asym_fifo_write_wider
  import asym_fifo_pkg::*;
#(
  parameter int unsigned AWA = 4,
  parameter int unsigned DWA = 16,
  parameter int unsigned DWB = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  asym_fifo_write_wider_if.slave bus
);

  localparam int unsigned RATIO = ratio_of(DWA, DWB);
  localparam int unsigned LR    = max_u(1, log2_ratio(DWA, DWB));
  localparam int unsigned AW    = AWA + LR;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = (1 << AWA) * RATIO;

  if (!params_ok(DWA, DWB)) begin : g_param_check
    $error("asym_fifo_write_wider: DWA must be a power-of-two multiple (>= 2) of DWB");
  end

  logic [AWA-1:0]            r_wptr;
  logic [AW-1:0]             r_rptr;
  logic [CW-1:0]             r_count;
  logic                      r_m_valid;
  logic                      w_wr;
  logic                      w_fetch;
  logic [RATIO-1:0][DWB-1:0] w_lanes;
  logic [DWB-1:0]            w_rd_data;

  // Full/empty come from the memory count, so pointers simply wrap.
  assign bus.s_ready = (r_count <= CW'(DEPTH - RATIO));
  assign w_wr        = bus.s_valid && bus.s_ready;
  assign w_fetch     = (r_count != '0) && (!r_m_valid || bus.m_ready);

  for (genvar j = 0; j < RATIO; j++) begin : g_lane
`ifdef ASYM_FIFO_MSB_LANE_FIRST_EN
    assign w_lanes[j] = bus.s_data[(RATIO-1-j)*DWB +: DWB];
`else
    assign w_lanes[j] = bus.s_data[j*DWB +: DWB];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AWA'(1);
      end
      if (w_fetch) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + (w_wr ? CW'(RATIO) : '0) - (w_fetch ? CW'(1) : '0);
      if (w_fetch) begin
        r_m_valid <= 1'b1;
      end else if (bus.m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  asym_fifo_mem #(
    .AWA   (AWA),
    .DWB   (DWB),
    .RATIO (RATIO),
    .LR    (LR)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wptr),
    .i_wr_data (w_lanes),
    .i_rd_en   (w_fetch),
    .i_rd_addr (r_rptr),
    .o_rd_data (w_rd_data)
  );

  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = w_rd_data;
  assign bus.level   = r_count + CW'(r_m_valid);

endmodule

// File: tb/tb_asym_fifo_write_wider.sv
// Directed bench for asym_fifo_write_wider with DWA=16, DWB=4, AWA=2 (16 narrow slots).
module tb_asym_fifo_write_wider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  asym_fifo_write_wider_if #(.AWA(2), .DWA(16), .DWB(4)) bus ();

  asym_fifo_write_wider #(.AWA(2), .DWA(16), .DWB(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] lane_of(input logic [15:0] w, input int k);
`ifdef ASYM_FIFO_MSB_LANE_FIRST_EN
    return w[(3-k)*4 +: 4];
`else
    return w[k*4 +: 4];
`endif
  endfunction

  logic [15:0] fw [4];
  logic [3:0]  q [$];
  logic [3:0]  e_nib;
  logic [15:0] wd;
  int          gaps;
  int          max_lvl;
  bit          started;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fw[0] = 16'h1234; fw[1] = 16'h5678; fw[2] = 16'h9ABC; fw[3] = 16'hDEF0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check_eq("rst_s_ready", 32'(bus.s_ready), 1);
    check_eq("rst_m_valid", 32'(bus.m_valid), 0);
    check_eq("rst_m_data",  32'(bus.m_data), 0);
    check_eq("rst_level",   32'(bus.level), 0);

    // Single wide word, consumer always ready
    bus.s_data = 16'hA5C3; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    step();
    bus.s_valid = 1'b0;
    check_eq("a_no_bypass", 32'(bus.m_valid), 0);
    check_eq("a_level_e0",  32'(bus.level), 4);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("a_valid", 32'(bus.m_valid), 1);
      check_eq("a_data",  32'(bus.m_data), 32'(lane_of(16'hA5C3, k)));
      check_eq("a_level", 32'(bus.level), 32'(4 - k));
    end
    step();
    check_eq("a_empty_valid", 32'(bus.m_valid), 0);
    check_eq("a_empty_level", 32'(bus.level), 0);

    // Fill with consumer stalled
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.s_data = fw[i]; bus.s_valid = 1'b1;
      step();
      check_eq("f_s_ready", 32'(bus.s_ready), (i < 3) ? 1 : 0);
      check_eq("f_level",   32'(bus.level), 32'(4 * (i + 1)));
    end
    bus.s_data = 16'h1111;
    step();
    step();
    bus.s_valid = 1'b0;
    check_eq("f_full_level",   32'(bus.level), 16);
    check_eq("f_full_s_ready", 32'(bus.s_ready), 0);
    check_eq("f_hold_valid",   32'(bus.m_valid), 1);
    check_eq("f_hold_data",    32'(bus.m_data), 32'(lane_of(fw[0], 0)));

    // Accept one narrow word at a time; s_ready returns once memory free >= 4
    for (int a = 1; a <= 4; a++) begin
      bus.m_ready = 1'b1;
      step();
      bus.m_ready = 1'b0;
      check_eq("p_data",    32'(bus.m_data), 32'(lane_of(fw[a / 4], a % 4)));
      check_eq("p_level",   32'(bus.level), 32'(16 - a));
      check_eq("p_s_ready", 32'(bus.s_ready), (a >= 3) ? 1 : 0);
    end
    bus.m_ready = 1'b1;
    for (int idx = 4; idx < 16; idx++) begin
      check_eq("d_valid", 32'(bus.m_valid), 1);
      check_eq("d_data",  32'(bus.m_data), 32'(lane_of(fw[idx / 4], idx % 4)));
      step();
    end
    check_eq("d_empty_valid", 32'(bus.m_valid), 0);
    check_eq("d_empty_level", 32'(bus.level), 0);

    // Streaming: one wide word every 4th cycle across several pointer wraps
    gaps = 0; max_lvl = 0; started = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.s_valid = (c % 4 == 0) && (c < 56);
      wd = 16'(c * 32'h1357 + 32'h0F0F);
      bus.s_data = wd;
      if (bus.s_valid) begin
        check_eq("c_s_ready", 32'(bus.s_ready), 1);
        for (int k = 0; k < 4; k++) q.push_back(lane_of(wd, k));
      end
      step();
      if (bus.m_valid) begin
        started = 1'b1;
        e_nib = (q.size() > 0) ? q.pop_front() : 4'hx;
        check_eq("c_data", 32'(bus.m_data), 32'(e_nib));
      end else if (started && q.size() != 0) begin
        gaps++;
      end
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
    end
    bus.s_valid = 1'b0;
    check_eq("c_gaps",      32'(gaps), 0);
    check_eq("c_max_level", 32'(max_lvl), 5);
    check_eq("c_leftover",  32'(q.size()), 0);
    check_eq("c_end_level", 32'(bus.level), 0);

    // Reset in the middle of a drain at level 7
    bus.m_ready = 1'b0;
    bus.s_data = 16'h3B6D; bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
    step();
    bus.s_data = 16'h8F1E; bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    check_eq("r_pre_level", 32'(bus.level), 7);
    check_eq("r_pre_data",  32'(bus.m_data), 32'(lane_of(16'h3B6D, 1)));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("r_async_valid", 32'(bus.m_valid), 0);
    check_eq("r_async_level", 32'(bus.level), 0);
    check_eq("r_async_data",  32'(bus.m_data), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_eq("r_post_s_ready", 32'(bus.s_ready), 1);
    check_eq("r_post_level",   32'(bus.level), 0);
    check_eq("r_post_valid",   32'(bus.m_valid), 0);
    bus.s_data = 16'h7E42; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    step();
    bus.s_valid = 1'b0;
    check_eq("r_no_bypass", 32'(bus.m_valid), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("r_valid", 32'(bus.m_valid), 1);
      check_eq("r_data",  32'(bus.m_data), 32'(lane_of(16'h7E42, k)));
    end
    step();
    check_eq("r_end_valid", 32'(bus.m_valid), 0);
    check_eq("r_end_level", 32'(bus.level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
